// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises rx_i, detects start bits and recovers bits by mid-bit
// majority-of-3 sampling. Define UART_RX_PARITY_EN to insert a parity bit after the data.
module uart_rx_sampler #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        en_i,
   input  logic        rx_i,
   input  logic [15:0] baud_div,
   input  logic        parity_odd_i,
   output logic [7:0]  dout_o,
   output logic        rx_done_tick_o,
   output logic        frame_err_o,
   output logic        parity_err_o,
   output logic        break_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } state_t;

   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

`ifdef UART_RX_PARITY_EN
   function automatic logic exp_parity(input logic [DATA_BITS-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction
`endif

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state, w_state_nxt;
   logic [15:0]            r_cnt, w_cnt_nxt;
   logic [15:0]            r_div, w_div_nxt;
   logic                   r_s0, w_s0_nxt;
   logic                   r_s1, w_s1_nxt;
   logic [2:0]             r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
   logic [7:0]             r_dout, w_dout_nxt, w_ext;
   logic                   r_done, w_done_nxt;
   logic                   r_ferr, w_ferr_nxt;
   logic                   r_brk, w_brk_nxt;
   logic                   r_busy;
   logic                   w_rxs, w_wrap, w_at_s2, w_maj;
   logic [15:0]            w_half, w_cnt_inc;
`ifdef UART_RX_PARITY_EN
   logic                   r_perr, w_perr_nxt;
   logic                   r_par_bad, w_par_bad_nxt;
   logic                   r_par_bit, w_par_bit_nxt;
`else
   logic                   w_unused;
   assign w_unused = parity_odd_i;
`endif

   // Bit-timing helpers derived from the divider latched at start detect
   always_comb begin
      w_rxs                = r_sync[SYNC_STAGES-1];
      w_half               = {1'b0, r_div[15:1]};
      w_wrap               = (r_cnt == (r_div - 16'd1));
      w_at_s2              = (r_cnt == (w_half + 16'd1));
      w_maj                = maj3(r_s0, r_s1, w_rxs);
      w_cnt_inc            = w_wrap ? 16'd0 : (r_cnt + 16'd1);
      w_ext                = 8'd0;
      w_ext[DATA_BITS-1:0] = r_shift;
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_dout_nxt  = r_dout;
      w_done_nxt  = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_brk_nxt   = r_brk;
`ifdef UART_RX_PARITY_EN
      w_perr_nxt    = 1'b0;
      w_par_bad_nxt = r_par_bad;
      w_par_bit_nxt = r_par_bit;
`endif
      if (r_cnt == (w_half - 16'd1)) w_s0_nxt = w_rxs;
      else                           w_s0_nxt = r_s0;
      if (r_cnt == w_half) w_s1_nxt = w_rxs;
      else                 w_s1_nxt = r_s1;

      if (!en_i) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = 16'd0;
         w_brk_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_cnt_nxt = 16'd0;
               w_bit_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
               w_par_bad_nxt = 1'b0;
               w_par_bit_nxt = 1'b0;
`endif
               if (!w_rxs && (baud_div >= 16'd4)) begin
                  w_state_nxt = ST_START;
                  w_div_nxt   = baud_div;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_START: begin
               w_cnt_nxt = w_cnt_inc;
               if (w_at_s2 && w_maj) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 16'd0;
               end else if (w_wrap) begin
                  w_state_nxt = ST_DATA;
               end else begin
                  w_state_nxt = ST_START;
               end
            end
            ST_DATA: begin
               w_cnt_nxt = w_cnt_inc;
               if (w_at_s2) w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
               else         w_shift_nxt = r_shift;
               if (w_wrap && (r_bit == BIT_LAST)) begin
                  w_bit_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else if (w_wrap) begin
                  w_bit_nxt = r_bit + 3'd1;
               end else begin
                  w_bit_nxt = r_bit;
               end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
               w_cnt_nxt = w_cnt_inc;
               if (w_at_s2) begin
                  w_par_bit_nxt = w_maj;
                  if (w_maj != exp_parity(r_shift, parity_odd_i)) begin
                     w_perr_nxt    = 1'b1;
                     w_par_bad_nxt = 1'b1;
                  end else begin
                     w_perr_nxt    = 1'b0;
                  end
               end else begin
                  w_par_bit_nxt = r_par_bit;
               end
               if (w_wrap) w_state_nxt = ST_STOP;
               else        w_state_nxt = ST_PARITY;
`else
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 16'd0;
`endif
            end
            ST_STOP: begin
               w_cnt_nxt = w_cnt_inc;
               if (w_at_s2 && w_maj) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 16'd0;
                  w_dout_nxt  = w_ext;
`ifdef UART_RX_PARITY_EN
                  w_done_nxt  = !r_par_bad;
`else
                  w_done_nxt  = 1'b1;
`endif
               end else if (w_at_s2) begin
                  w_state_nxt = ST_BRK;
                  w_cnt_nxt   = 16'd0;
                  w_ferr_nxt  = 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_brk_nxt   = (r_shift == {DATA_BITS{1'b0}}) && !r_par_bit;
`else
                  w_brk_nxt   = (r_shift == {DATA_BITS{1'b0}});
`endif
               end else begin
                  w_state_nxt = ST_STOP;
               end
            end
            ST_BRK: begin
               if (w_rxs) begin
                  w_state_nxt = ST_IDLE;
                  w_brk_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_BRK;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 16'd0;
               w_brk_nxt   = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and registered outputs; the sync chain presets high so reset never looks like a start bit
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_sync  <= {SYNC_STAGES{1'b1}};
         r_state <= ST_IDLE;
         r_cnt   <= 16'd0;
         r_div   <= 16'd0;
         r_s0    <= 1'b0;
         r_s1    <= 1'b0;
         r_bit   <= 3'd0;
         r_shift <= {DATA_BITS{1'b0}};
         r_dout  <= 8'd0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
         r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr    <= 1'b0;
         r_par_bad <= 1'b0;
         r_par_bit <= 1'b0;
`endif
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_i};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_div   <= w_div_nxt;
         r_s0    <= w_s0_nxt;
         r_s1    <= w_s1_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_dout  <= w_dout_nxt;
         r_done  <= w_done_nxt;
         r_ferr  <= w_ferr_nxt;
         r_brk   <= w_brk_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef UART_RX_PARITY_EN
         r_perr    <= w_perr_nxt;
         r_par_bad <= w_par_bad_nxt;
         r_par_bit <= w_par_bit_nxt;
`endif
      end
   end

   assign dout_o         = r_dout;
   assign rx_done_tick_o = r_done;
   assign frame_err_o    = r_ferr;
   assign break_o        = r_brk;
   assign busy_o         = r_busy;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o   = r_perr;
`else
   assign parity_err_o   = 1'b0;
`endif

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
Serial front end of the UART receive path. Synchronises the asynchronous rx pin and detects the start bit. Recovers each bit by mid-bit majority-of-3 sampling, driven by the run-time divider baud_div (clk freq / baud rate). Delivers the received byte with a one-cycle done tick directly to the rx FIFO-writer stage, and flags framing errors and line breaks for the status register.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; 5..8 legal.
SYNC_STAGES, 2, flip-flop stages on rx_i before any logic; minimum 2.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset; synchronous, active-low
en_i  in  1  receiver enable; 0 aborts any frame and holds IDLE
rx_i  in  1  asynchronous serial input, idle high
baud_div  in  16  clock cycles per bit; values below 4 unsupported
parity_odd_i  in  1  parity sense, 1 = odd (used only with UART_RX_PARITY_EN)
dout_o  out  8  received byte, zero-extended when DATA_BITS < 8
rx_done_tick_o  out  1  one-cycle pulse: dout_o valid, frame good
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
parity_err_o  out  1  one-cycle pulse: parity mismatch
break_o  out  1  level: break condition active
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0. State IDLE, counters 0, and the sync chain is preset to 1 so no false start is seen after reset.
- Reset asserted mid-frame aborts the frame. No tick is issued and no partial byte is visible on dout_o.
- rxs is the last sync stage. The start condition is rxs = 0 in IDLE.
- The bit counter cnt runs 0..baud_div-1 and wraps to 0. Let h = baud_div >> 1.
- Each bit is sampled at cnt = h-1, h, and h+1. The bit value is the majority of the 3 samples.
- States:
  - IDLE: on start condition with en_i = 1 and baud_div >= 4, set cnt to 0 and go to START.
  - START: at cnt = h+1, majority 1 means a glitch; return to IDLE with no flag. Otherwise, at the wrap, go to DATA.
  - DATA: shift the majority value into the MSB of a DATA_BITS shift register (LSB first). After bit DATA_BITS-1 wraps, go to PARITY if the macro is defined, else STOP.
  - PARITY: macro only; see Optional Feature.
  - STOP: decided at cnt = h+1, with no wait for the wrap, so a back-to-back start bit is caught.
    - Majority 1: load dout_o and pulse rx_done_tick_o on the next cycle, then go to IDLE.
    - Majority 0: pulse frame_err_o; dout_o is not updated and there is no done tick.
      - If all data bits were 0 (and parity bit 0 if present), set break_o and go to BRK.
      - Otherwise go to BRK without setting break_o.
  - BRK: wait until rxs = 1, then clear break_o and go to IDLE.
- rx_done_tick_o latency: exactly 1 clk after the third stop sample, i.e. SYNC_STAGES + 1 cycles after that sample point on rx_i.
- dout_o holds its value until the next good frame.
- en_i = 0 in any state: return to IDLE next cycle, clear break_o, no tick.
- baud_div is sampled at start detect and held for the whole frame. A mid-frame change has no effect until the next frame.
- baud_div < 4: start bits are ignored and the block stays in IDLE.
- At most one of rx_done_tick_o, frame_err_o, parity_err_o is high in any cycle. parity_err_o and frame_err_o of the same frame are reported in their own cycles.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state is inserted after DATA, sampled like any other bit.
  - Expected parity = XOR of the data bits, inverted when parity_odd_i = 1.
  - On mismatch, parity_err_o pulses at the parity bit's h+1 sample. The frame continues to STOP; rx_done_tick_o is still suppressed for that frame while dout_o still updates.
- Not defined: frames are DATA_BITS-N-1, parity_odd_i is ignored, parity_err_o is tied 0.

Test Plan:
- Good frame: baud_div=16, send 0xA5 (8N1) → rx_done_tick_o one cycle, dout_o=0xA5, frame_err_o=0, busy_o low after stop.
- Back-to-back frames: 0x00 then 0xFF with no idle gap, baud_div=16 → two done ticks, dout_o 0x00 then 0xFF, no error pulses.
- Glitch: rx_i low for 3 cycles, baud_div=16 → start rejected, no tick, busy_o back to 0 within 10 cycles.
- Framing and break: data 0x3C with stop bit 0 → frame_err_o pulse, dout_o unchanged, break_o stays 0. Line held low for 2 full frames → frame_err_o pulse and break_o=1 until rx_i returns high.
- Reset and enable: assert rstn_i=0 during data bit 4 → all outputs 0, next good frame 0x5A received correctly. en_i=0 mid-frame → no tick.
- Parity (UART_RX_PARITY_EN, parity_odd_i=0): 0x07 with parity bit 1 → done tick. With parity bit 0 → parity_err_o pulse and no done tick.
